updown_counter_axil_mc: RTL
===========================

Name: updown_counter_axil_mc

Overview:
- Multi-channel successor to the single AXI4-Lite up/down counter IP.
- Provides N_CH independent counters of parametrised width, each with direction, wrap/saturate mode, load value, sticky terminal-count status and a maskable interrupt.
- Counters advance on external per-channel event pulses.
- Sits as an AXI4-Lite slave on the PS interconnect; the counter values are also exported as a flat bus for PL logic.

Parameters:
N_CH, 4, number of counter channels (1..16)
CNT_WIDTH, 32, counter width in bits (1..32); reads are zero-extended to 32
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
C_S_AXI_ADDR_WIDTH, 8, byte address width; must cover N_CH*16 bytes

Ports:
s00_axi_aclk  in  1  clock
s00_axi_areset  in  1  synchronous reset, active-high
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid/awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid/wready  in/out  1  W handshake
s00_axi_bresp  out  2  always OKAY
s00_axi_bvalid/bready  out/in  1  B handshake
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid/arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  always OKAY
s00_axi_rvalid/rready  out/in  1  R handshake
count_ev  in  N_CH  per-channel count event, one count per high cycle
count_o  out  N_CH*CNT_WIDTH  live counter values, channel 0 in the LSBs
irq  out  1  OR over channels of (TC & IRQEN), registered

Behaviour:
- Reset: all counters, LOAD and CTRL registers are 0, and TC is cleared. awready, wready, bvalid, arready, rvalid and irq are 0. rdata is 0.
- Register map, channel c at base c*0x10:
  - +0x0 CTRL: [0] EN, [1] DIR (0 up, 1 down), [2] SAT (1 saturate, 0 auto-reload), [3] LD (write-1 pulse, reads 0), [4] IRQEN.
  - +0x4 LOAD value.
  - +0x8 COUNT, read-only.
  - +0xC STATUS: [0] TC, sticky, write-1-to-clear.
- Addresses at or above N_CH*0x10 read 0. Writes to them are ignored. Responses are OKAY throughout.
- Write path: awready and wready pulse together for one cycle when awvalid && wvalid && !bvalid. The register updates on that edge, honouring wstrb per byte. bvalid rises the next cycle and holds until bready. Only one write is outstanding at a time.
- Read path: arready pulses for one cycle when arvalid && !rvalid. rdata and rvalid are registered one cycle later. rvalid holds until rready. COUNT reads return the value sampled at the AR handshake.
- Count step, per channel per cycle, in priority order:
  1. LD write: count <= LOAD. Any event that cycle is dropped.
  2. EN && count_ev, DIR=0: if count==MAX, set TC; then SAT holds MAX, otherwise count <= LOAD. Else count+1.
  3. EN && count_ev, DIR=1: if count==0, set TC; then SAT holds 0, otherwise count <= LOAD. Else count-1.
- MAX = 2^CNT_WIDTH-1.
- LD and LOAD written in the same transaction is not possible (different addresses). LD uses the LOAD register value current at that edge.
- TC set and a W1C in the same cycle: set wins.
- irq is registered, so it is 1 cycle behind TC/IRQEN.
- count_o is driven directly from the counter registers, zero latency after the edge.
- Reset asserted mid-transaction: handshakes are abandoned and all outputs return to reset values on the next edge.

Decomposition:
- Package updown_counter_pkg:
  - register offsets (CTRL/LOAD/COUNT/STATUS);
  - CTRL bit indices;
  - channel stride 0x10;
  - typedef ctrl_t (packed struct en/dir/sat/irqen).
- Sub-module updown_counter_channel holds one counter, LOAD, CTRL, TC and its step logic; it is generated N_CH times.
- The top level holds the AXI4-Lite FSM, address decode and read mux.

Test Plan:
- Reset, then read all registers of all channels -> every read returns 0, bresp/rresp OKAY, irq=0.
- ch0: LOAD=5, LD, EN=1 up; 3 count_ev pulses -> COUNT reads 8 and count_o[31:0]=8.
- ch1 CNT_WIDTH=32: LOAD=0xFFFFFFFE, up, SAT=0, IRQEN=1; 3 events:
  - COUNT sequence FFFFFFFF, FFFFFFFE, FFFFFFFF;
  - TC=1 and irq=1 two cycles after the wrap edge;
  - W1C STATUS -> irq=0.
- ch2 down, SAT=1 from LOAD=1; 4 events -> COUNT=0 held, TC=1. Same-cycle event and TC W1C -> TC stays 1.
- Write CTRL with wstrb=4'b0000 -> CTRL unchanged. Read address N_CH*0x10 -> 0, OKAY. bready held low 5 cycles -> bvalid stays 1 and the next write is not accepted.
- LD write coincident with a count_ev on ch3 -> COUNT equals LOAD, event dropped. Assert reset mid-read -> rvalid=0 and all counts 0 next cycle.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// Shared definitions for the multi-channel AXI4-Lite up/down counter.
// Holds the per-channel register byte offsets, CTRL bit positions, the
// channel address stride, the packed control-register type, the bus FSM
// state types and a helper that formats CTRL for read-back.
package updown_counter_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_LOAD   = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_DIR   = 1;
    localparam int CTRL_SAT   = 2;
    localparam int CTRL_LD    = 3;
    localparam int CTRL_IRQEN = 4;

    localparam int CH_STRIDE = 'h10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic irqen;
        logic sat;
        logic dir;
        logic en;
    } ctrl_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ACCEPT,
        WR_RESP
    } wrState_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ACCEPT,
        RD_RESP
    } rdState_t;

    // LD is a write-only pulse, so its bit position always reads back as 0.
    function automatic logic [31:0] ctrlToWord(ctrl_t c);
        return {27'd0, c.irqen, 1'b0, c.sat, c.dir, c.en};
    endfunction

endpackage

// File: rtl/updown_counter_channel.sv
// One counter channel: COUNT, LOAD, CTRL and the sticky TC flag, plus the
// per-cycle count step.
// Ports:
//   clk_i, reset_i      clock and synchronous active-high reset
//   wrEn_i              a write to this channel completes on this edge
//   wrOff_i             register byte offset within the channel (word aligned)
//   wdata_i, wstrb_i    write data and byte strobes
//   countEv_i           count event, one step per high cycle
//   count_o, load_o     current COUNT and LOAD values
//   ctrl_o, tc_o        current control bits and terminal-count flag
module updown_counter_channel
    import updown_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 wrEn_i,
    input  logic [3:0]           wrOff_i,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           wstrb_i,
    input  logic                 countEv_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic [CNT_WIDTH-1:0] load_o,
    output ctrl_t                ctrl_o,
    output logic                 tc_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_VAL = '1;

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] load_q, load_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic                 tc_q, tc_d;

    logic        ldPulse;
    logic        tcSet;
    logic        tcClr;
    logic [31:0] loadMerged;

    // Register writes and the count step. LD and events both use the LOAD
    // value held before this edge; a TC set outranks a same-cycle clear.
    always_comb begin
        count_d    = count_q;
        load_d     = load_q;
        ctrl_d     = ctrl_q;
        ldPulse    = 1'b0;
        tcSet      = 1'b0;
        tcClr      = 1'b0;
        loadMerged = 32'(load_q);

        if (wrEn_i) begin
            case (wrOff_i)
                OFF_CTRL: begin
                    if (wstrb_i[0]) begin
                        ctrl_d.en    = wdata_i[CTRL_EN];
                        ctrl_d.dir   = wdata_i[CTRL_DIR];
                        ctrl_d.sat   = wdata_i[CTRL_SAT];
                        ctrl_d.irqen = wdata_i[CTRL_IRQEN];
                        ldPulse      = wdata_i[CTRL_LD];
                    end
                end
                OFF_LOAD: begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_i[b]) begin
                            loadMerged[8*b +: 8] = wdata_i[8*b +: 8];
                        end
                    end
                    load_d = loadMerged[CNT_WIDTH-1:0];
                end
                OFF_STATUS: begin
                    tcClr = wstrb_i[0] && wdata_i[0];
                end
                default: begin
                end
            endcase
        end

        if (ldPulse) begin
            count_d = load_q;
        end else if (ctrl_q.en && countEv_i) begin
            if (!ctrl_q.dir) begin
                if (count_q == MAX_VAL) begin
                    tcSet   = 1'b1;
                    count_d = ctrl_q.sat ? MAX_VAL : load_q;
                end else begin
                    count_d = count_q + CNT_WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tcSet   = 1'b1;
                    count_d = ctrl_q.sat ? '0 : load_q;
                end else begin
                    count_d = count_q - CNT_WIDTH'(1);
                end
            end
        end

        tc_d = tcSet || (tc_q && !tcClr);
    end

    // Channel state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
            load_q  <= '0;
            ctrl_q  <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            load_q  <= load_d;
            ctrl_q  <= ctrl_d;
            tc_q    <= tc_d;
        end
    end

    assign count_o = count_q;
    assign load_o  = load_q;
    assign ctrl_o  = ctrl_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/updown_counter_axil_mc.sv
// Multi-channel up/down counter behind an AXI4-Lite slave.
// Ports:
//   s00_axi_*   AXI4-Lite slave (clock, sync active-high reset, AW/W/B/AR/R)
//   count_ev    per-channel count event
//   count_o     live counter values, channel 0 in the LSBs
//   irq         registered OR over channels of (TC & IRQEN)
module updown_counter_axil_mc
    import updown_counter_pkg::*;
#(
    parameter int N_CH               = 4,
    parameter int CNT_WIDTH          = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                    s00_axi_awprot,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                    s00_axi_arprot,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    input  logic [N_CH-1:0]               count_ev,
    output logic [N_CH*CNT_WIDTH-1:0]     count_o,
    output logic                          irq
);

    wrState_t wrState_q, wrState_d;
    rdState_t rdState_q, rdState_d;
    logic [31:0] rdata_q;
    logic        irq_q;

    logic        wrFire;
    logic        arFire;
    logic [31:0] rdMux;

    logic [CNT_WIDTH-1:0] chCount [N_CH];
    logic [CNT_WIDTH-1:0] chLoad  [N_CH];
    ctrl_t                chCtrl  [N_CH];
    logic [N_CH-1:0]      chTc;
    logic [N_CH-1:0]      chIrq;
    logic [N_CH-1:0]      chWrEn;

    logic unusedProt;
    assign unusedProt = &{1'b0, s00_axi_awprot, s00_axi_arprot};

    // AW and W are only taken together; the register write happens on the
    // edge that completes the handshake, and B follows from the next cycle.
    assign wrFire = (wrState_q == WR_ACCEPT) && s00_axi_awvalid && s00_axi_wvalid;
    assign arFire = (rdState_q == RD_ACCEPT) && s00_axi_arvalid;

    // Write FSM next state and handshake outputs.
    always_comb begin
        wrState_d       = wrState_q;
        s00_axi_awready = 1'b0;
        s00_axi_wready  = 1'b0;
        s00_axi_bvalid  = 1'b0;
        case (wrState_q)
            WR_IDLE: begin
                if (s00_axi_awvalid && s00_axi_wvalid) wrState_d = WR_ACCEPT;
            end
            WR_ACCEPT: begin
                s00_axi_awready = 1'b1;
                s00_axi_wready  = 1'b1;
                if (wrFire) wrState_d = WR_RESP;
            end
            WR_RESP: begin
                s00_axi_bvalid = 1'b1;
                if (s00_axi_bready) wrState_d = WR_IDLE;
            end
            default: wrState_d = WR_IDLE;
        endcase
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        rdState_d       = rdState_q;
        s00_axi_arready = 1'b0;
        s00_axi_rvalid  = 1'b0;
        case (rdState_q)
            RD_IDLE: begin
                if (s00_axi_arvalid) rdState_d = RD_ACCEPT;
            end
            RD_ACCEPT: begin
                s00_axi_arready = 1'b1;
                if (arFire) rdState_d = RD_RESP;
            end
            RD_RESP: begin
                s00_axi_rvalid = 1'b1;
                if (s00_axi_rready) rdState_d = RD_IDLE;
            end
            default: rdState_d = RD_IDLE;
        endcase
    end

    // Read mux; addresses beyond the last channel match no channel and read 0.
    always_comb begin
        rdMux = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (int'(s00_axi_araddr) / CH_STRIDE == c) begin
                case ({s00_axi_araddr[3:2], 2'b00})
                    OFF_CTRL:   rdMux = ctrlToWord(chCtrl[c]);
                    OFF_LOAD:   rdMux = 32'(chLoad[c]);
                    OFF_COUNT:  rdMux = 32'(chCount[c]);
                    OFF_STATUS: rdMux = {31'd0, chTc[c]};
                    default:    rdMux = '0;
                endcase
            end
        end
    end

    // Bus state, captured read data and the registered interrupt.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wrState_q <= WR_IDLE;
            rdState_q <= RD_IDLE;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            wrState_q <= wrState_d;
            rdState_q <= rdState_d;
            if (arFire) rdata_q <= rdMux;
            irq_q     <= |chIrq;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : gCh
        assign chWrEn[c] = wrFire && (int'(s00_axi_awaddr) / CH_STRIDE == c);

        updown_counter_channel #(
            .CNT_WIDTH (CNT_WIDTH)
        ) uChannel (
            .clk_i     (s00_axi_aclk),
            .reset_i   (s00_axi_areset),
            .wrEn_i    (chWrEn[c]),
            .wrOff_i   ({s00_axi_awaddr[3:2], 2'b00}),
            .wdata_i   (s00_axi_wdata),
            .wstrb_i   (s00_axi_wstrb),
            .countEv_i (count_ev[c]),
            .count_o   (chCount[c]),
            .load_o    (chLoad[c]),
            .ctrl_o    (chCtrl[c]),
            .tc_o      (chTc[c])
        );

        assign count_o[c*CNT_WIDTH +: CNT_WIDTH] = chCount[c];
        assign chIrq[c] = chTc[c] && chCtrl[c].irqen;
    end

    assign s00_axi_bresp = RESP_OKAY;
    assign s00_axi_rresp = RESP_OKAY;
    assign s00_axi_rdata = rdata_q;
    assign irq           = irq_q;

endmodule
